// File: rtl/byte_lsu.sv
// byte_lsu: load/store initiator between the execute stage and a byte-wide data memory.
//
// Accepts one RV32I LB/LH/LW/LBU/LHU/SB/SH/SW request at a time. Each request becomes 1, 2
// or 4 byte transactions on the memory port, one after another, each using a req/ack
// handshake. Load bytes are assembled little-endian. The result is sign- or zero-extended
// and returned with a one-cycle resp_valid pulse.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   req_valid/req_ready      pipeline request handshake (ready only when idle)
//   req_we, req_funct3       store flag and RV32I load/store funct3
//   req_addr, req_wdata      byte address and store data
//   resp_valid, resp_err     completion pulse; error (illegal request or timeout)
//   resp_rdata               extended load result, held until the next completion
//   mem_en/mem_ack           byte transaction request / completion
//   mem_we, mem_addr         byte write flag and byte address
//   mem_wdata, mem_rdata     write byte / read byte (valid with mem_ack)
//
// Build option
//   MISALIGN_TRAP_EN  when defined, misaligned halfword/word requests are rejected with
//                     resp_err and issue no memory transaction. When undefined, they are
//                     performed as consecutive byte transactions (address wraps silently).

module byte_lsu #(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic                     resp_err,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [7:0]               mem_wdata,
    input  logic [7:0]               mem_rdata,
    input  logic                     mem_ack
);

    localparam int unsigned TmoWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TmoLast  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TmoWidth-1:0] TmoLastW = TmoLast[TmoWidth-1:0];

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e                   state_q, state_d;
    logic                     we_q;
    logic [2:0]               funct3_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [1:0]               idx_q, idx_d;
    logic [TmoWidth-1:0]      tmo_q, tmo_d;
    logic [31:0]              rbuf_q, rbuf_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     err_q, err_d;

    logic        accept;
    logic        illegal;
    logic        misaligned;
    logic [1:0]  last_idx;
    logic [31:0] assembled;
    logic [31:0] extended;

    assign accept = req_valid && (state_q == StIdle);

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // funct3 011/110/111 are not loads or stores; stores have no unsigned forms.
    assign illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                     (req_we && req_funct3[2]) || misaligned;

    always_comb begin
        last_idx = 2'd3;
        unique case (funct3_q[1:0])
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    // Load buffer with the byte being acknowledged this cycle merged in, so the final
    // result can be extended and registered on the last ack without an extra cycle.
    always_comb begin
        assembled = rbuf_q;
        assembled[{idx_q, 3'b000} +: 8] = mem_rdata;
    end

    always_comb begin
        extended = assembled;
        unique case (funct3_q)
            3'b000:  extended = {{24{assembled[7]}}, assembled[7:0]};
            3'b001:  extended = {{16{assembled[15]}}, assembled[15:0]};
            3'b100:  extended = {24'd0, assembled[7:0]};
            3'b101:  extended = {16'd0, assembled[15:0]};
            default: extended = assembled;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    idx_d  = 2'd0;
                    tmo_d  = '0;
                    rbuf_d = '0;
                    if (illegal) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                if (mem_ack) begin
                    tmo_d = '0;
                    if (!we_q) begin
                        rbuf_d = assembled;
                    end
                    if (idx_q == last_idx) begin
                        state_d = StDone;
                        err_d   = 1'b0;
                        rdata_d = we_q ? '0 : extended;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TmoLastW)) begin
                    // Bytes already written stay written; the load result is discarded.
                    state_d = StDone;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            tmo_q   <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StDone);
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;

    // Memory outputs are forced to zero outside ACCESS. They stay stable while waiting
    // for mem_ack because idx_q only advances on an ack.
    assign mem_en    = (state_q == StAccess);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = mem_en ? (addr_q + ADDRESS_WIDTH'(idx_q)) : '0;
    assign mem_wdata = mem_en ? wdata_q[{idx_q, 3'b000} +: 8] : 8'd0;

endmodule

// File: tb/tb_byte_lsu.sv
// Testbench for byte_lsu. It includes a behavioural byte memory with per-byte acknowledge
// delays, directed scenarios and a randomized sweep. Expected values come from a simple
// arithmetic model of the load/store rules.

module tb_byte_lsu;

    localparam int unsigned Tmo = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    byte_lsu #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_err  (resp_err),
        .resp_rdata(resp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Behavioural memory; unwritten locations read back a fixed address-derived pattern.
    logic [7:0] mem [logic [31:0]];

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    int          dly [4];
    int          byte_no   = 0;
    int          wait_cnt  = 0;
    bit          ack_given = 0;
    bit          no_ack    = 0;
    logic [31:0] hold_addr;
    logic        hold_we;
    logic [7:0]  hold_wd;
    logic [31:0] log_addr [$];
    logic        log_we   [$];
    logic [7:0]  log_wd   [$];

    // Memory responder: acknowledges byte n after dly[n] wait cycles; random acks while idle.
    always @(negedge clk) begin
        if (ack_given) begin
            byte_no++;
            wait_cnt  = 0;
            ack_given = 0;
        end
        mem_ack = 1'b0;
        if (rst || !mem_en) begin
            wait_cnt  = 0;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = 8'($urandom);
        end else begin
            if (wait_cnt == 0) begin
                hold_addr = mem_addr;
                hold_we   = mem_we;
                hold_wd   = mem_wdata;
            end else begin
                check_eq("hold_addr", mem_addr, hold_addr);
                check_eq("hold_we", 32'(mem_we), 32'(hold_we));
                check_eq("hold_wdata", 32'(mem_wdata), 32'(hold_wd));
            end
            if (!no_ack && wait_cnt >= dly[byte_no % 4]) begin
                mem_ack   = 1'b1;
                mem_rdata = rd(mem_addr);
                if (mem_we) mem[mem_addr] = mem_wdata;
                log_addr.push_back(mem_addr);
                log_we.push_back(mem_we);
                log_wd.push_back(mem_wdata);
                ack_given = 1;
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        bit          legal;
        int          size;
        int          lat;
        int          k;
        int          exp_n;
        logic [31:0] v;
        logic [31:0] exp_rd;
        logic        exp_err;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (we && f3[2]));
`ifdef MISALIGN_TRAP_EN
        if ((size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00)) legal = 0;
`endif
        exp_err = 1'b0;
        exp_rd  = 32'd0;
        exp_n   = 0;
        lat     = 1;
        if (!legal) begin
            exp_err = 1'b1;
        end else if (no_ack) begin
            exp_err = 1'b1;
            lat     = Tmo + 1;
        end else begin
            exp_n = size;
            for (int i = 0; i < size; i++) lat += dly[i] + 1;
            if (!we) begin
                v = 0;
                for (int i = size - 1; i >= 0; i--) v = v * 256 + 32'(rd(addr + i));
                if (f3 == 3'd0 && v >= 128) v = v - 256;
                if (f3 == 3'd1 && v >= 32768) v = v - 65536;
                exp_rd = v;
            end
        end

        @(negedge clk);
        log_addr.delete();
        log_we.delete();
        log_wd.delete();
        byte_no = 0;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("ready_before", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        check_eq("busy_ready", 32'(req_ready), 32'd0);
        k = 1;
        while (!resp_valid && k < 200) begin
            if (k == 1) begin
                // A request presented while busy must be ignored.
                req_valid  = 1'b1;
                req_we     = ~we;
                req_funct3 = 3'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        req_valid = 1'b0;
        check_eq("resp_valid", 32'(resp_valid), 32'd1);
        check_eq("latency", k, lat);
        check_eq("resp_err", 32'(resp_err), 32'(exp_err));
        check_eq("resp_rdata", resp_rdata, exp_rd);
        check_eq("n_bytes", log_addr.size(), exp_n);
        for (int i = 0; i < exp_n && i < log_addr.size(); i++) begin
            check_eq("byte_addr", log_addr[i], addr + i);
            check_eq("byte_we", 32'(log_we[i]), 32'(we));
            if (we) check_eq("byte_wdata", 32'(log_wd[i]), (wd >> (8 * i)) & 32'hFF);
        end
        @(negedge clk);
        check_eq("one_pulse", 32'(resp_valid), 32'd0);
        check_eq("ready_after", 32'(req_ready), 32'd1);
        check_eq("rdata_held", resp_rdata, exp_rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_a;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 8'd0;
        for (int i = 0; i < 4; i++) dly[i] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp_err", 32'(resp_err), 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);

        // LW with zero-wait memory.
        mem[32'h10000] = 8'h78;
        mem[32'h10001] = 8'h56;
        mem[32'h10002] = 8'h34;
        mem[32'h10003] = 8'h12;
        run_op(1'b0, 3'b010, 32'h0001_0000, 32'd0);

        // Sign/zero extension.
        mem[32'h20] = 8'h80;
        mem[32'h21] = 8'hFF;
        run_op(1'b0, 3'b000, 32'h20, 32'd0);
        run_op(1'b0, 3'b100, 32'h20, 32'd0);
        run_op(1'b0, 3'b001, 32'h20, 32'd0);
        run_op(1'b0, 3'b101, 32'h20, 32'd0);

        // Misaligned SH with three wait cycles per byte.
        for (int i = 0; i < 4; i++) dly[i] = 3;
        run_op(1'b1, 3'b001, 32'h31, 32'hAABB_CCDD);
        for (int i = 0; i < 4; i++) dly[i] = 0;

        // Illegal requests.
        run_op(1'b0, 3'b011, 32'h40, 32'd0);
        run_op(1'b1, 3'b100, 32'h40, 32'h1234_5678);
        run_op(1'b0, 3'b111, 32'h40, 32'd0);

        // Timeout on a load that is never acknowledged.
        no_ack = 1;
        run_op(1'b0, 3'b010, 32'h50, 32'd0);
        no_ack = 0;

        // Reset in the middle of a wrapping SW.
        @(negedge clk);
        byte_no    = 0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'hFFFF_FFFE;
        req_wdata  = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
`ifdef MISALIGN_TRAP_EN
        exp_a = 32'd0;
`else
        exp_a = 32'hFFFF_FFFF;
`endif
        check_eq("rst_mid_addr", mem_addr, exp_a);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_mem_en", 32'(mem_en), 32'd0);
        check_eq("abort_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check_eq("abort_no_resp", 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        run_op(1'b1, 3'b010, 32'hFFFF_FFFE, 32'hCAFE_F00D);

        // Randomized sweep.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            for (int i = 0; i < 4; i++) dly[i] = $urandom_range(0, 3);
            no_ack = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                            : 32'h100 + $urandom_range(0, 63);
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end
        no_ack = 0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/byte_lsu.md
Name: byte_lsu

Overview:
- Load/store initiator between the execute stage and a byte-wide data memory port.
- Accepts one LB/LH/LW/LBU/LHU/SB/SH/SW request at a time.
- Issues it to memory as a sequence of 1, 2 or 4 byte transactions, each using a request/acknowledge handshake.
- For loads, assembles the bytes little-endian and sign- or zero-extends the result before returning it to the pipeline.

Parameters:
- ADDRESS_WIDTH, 32, request and memory address width.
- DATA_WIDTH, 32, pipeline data width; fixed at 32.
- TIMEOUT_CYCLES, 255, maximum wait cycles per byte for mem_ack; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  pipeline request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I load/store funct3.
- req_addr  input  ADDRESS_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data.
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  valid with resp_valid; illegal request or timeout.
- resp_rdata  output  DATA_WIDTH  extended load result; 0 for stores and errors.
- mem_en  output  1  byte transaction request.
- mem_we  output  1  byte write.
- mem_addr  output  ADDRESS_WIDTH  byte address.
- mem_wdata  output  8  write byte.
- mem_rdata  input  8  read byte; valid when mem_ack is high.
- mem_ack  input  1  transaction complete; may be high in the same cycle mem_en rises.

Behaviour:

Reset and handshake:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; byte index and timeout counter cleared.
- A request is accepted when req_valid and req_ready are both high. req_ready is high only in IDLE.
- On acceptance, capture we, funct3, addr and wdata. Size = 1/2/4 bytes for funct3[1:0] = 00/01/10.

Illegal requests:
- Illegal: funct3 = 011, 110 or 111, or a store with funct3[2]=1.
- Action: go directly to DONE with resp_err=1 and no memory transaction.

States:
- IDLE: wait for acceptance, then go to ACCESS (or DONE if illegal).
- ACCESS: mem_en=1, mem_addr = base + idx (modulo 2^ADDRESS_WIDTH, wraps silently), mem_we = captured we, mem_wdata = wdata[8*idx+7 : 8*idx].
  - Outputs are held stable until mem_ack.
  - On mem_ack, a load stores mem_rdata into byte idx, and idx increments.
  - If the byte just acked is the last byte, go to DONE. Otherwise present the next byte in the following cycle with mem_en kept high.
- DONE: resp_valid=1 for exactly one cycle; mem_en=0; return to IDLE.

Timing:
- With zero-wait mem_ack: LW accepted in cycle 0, bytes in cycles 1–4, resp_valid in cycle 5, next request accepted in cycle 6. LB gives resp_valid in cycle 2.

Load result extension:
- LB: sign-extend bit 7.
- LH: sign-extend bit 15.
- LBU / LHU: zero-extend.
- LW: raw 32 bits.
- resp_rdata is held until the next DONE. Stores return resp_rdata=0.

Timeout:
- The counter resets on each new byte and increments each ACCESS cycle without mem_ack.
- When it reaches TIMEOUT_CYCLES: go to DONE with resp_err=1 and resp_rdata=0. Bytes already written stay written.

Other boundary conditions:
- mem_ack while mem_en=0 is ignored.
- req_valid outside IDLE is ignored and not queued.
- rst in any state aborts the operation: no resp_valid, mem_en=0 the next cycle, state IDLE.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0]=1, or a word with addr[1:0]≠0, is rejected like an illegal request. It goes to DONE with resp_err=1 and issues no memory transaction.
- Undefined: misaligned accesses are performed normally as consecutive byte transactions, including wrap past the top address.

Test Plan:
- LW at 0x0001_0000, memory bytes 0x78,0x56,0x34,0x12, mem_ack tied high → mem_addr 0x10000..0x10003 in cycles 1–4; resp_valid in cycle 5 with resp_rdata=0x12345678, resp_err=0.
- LB then LBU at address 0x20 holding 0x80 → resp_rdata 0xFFFFFF80 then 0x00000080; LH at 0x20 with bytes 0x80,0xFF → 0xFFFFFF80.
- SH addr 0x31, wdata 0xAABBCCDD, mem_ack delayed 3 cycles per byte → writes 0xDD@0x31, then 0xCC@0x32. Outputs are stable while waiting. resp_valid occurs once with resp_err=0 (without MISALIGN_TRAP_EN); with the macro, resp_err=1 and mem_en never asserts.
- funct3=011 load, and SB-shaped store with funct3=100 → resp_valid in cycle 1 with resp_err=1, mem_en never asserts.
- LW with mem_ack never asserted, TIMEOUT_CYCLES=4 → resp_err=1, resp_rdata=0 after 4 wait cycles; req_ready high the following cycle.
- rst asserted during byte 2 of SW at 0xFFFFFFFE → no resp_valid, mem_en low next cycle, req_ready=1. Rerun without rst → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
